// File: rtl/cpu_pkg.sv
// Shared fetch-path constants and types for the pipelined MIPS core.
// Vectors live in kernel space (bit 31 set); the reset vector is a user address.
package cpu_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] IRQ_VECTOR = 32'h8040_0004;
    localparam logic [31:0] EXC_VECTOR = 32'h8040_0008;
    localparam logic [4:0]  REG_K0     = 5'd26;

    typedef enum logic [2:0] {
        PC_SEQ,
        PC_BR,
        PC_JMP,
        PC_IRQ,
        PC_EXC,
        PC_HOLD
    } pc_src_e;

    typedef enum logic {
        ST_RUN,
        ST_ENTER
    } fetch_state_e;

    // Sequential fetch keeps the mode bit: user code can never fall into kernel space.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Priority select of the next fetch address.
// While the vector-entry window is open only an exception can redirect fetch.
module pc_next_mux
    import cpu_pkg::*;
(
    input  logic        in_enter,
    input  logic        exc_req,
    input  logic        irq,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_taken,
    input  logic [31:0] jump_target,
    input  logic [31:0] pc,
    output pc_src_e     pc_src,
    output logic [31:0] pc_next
);

    always_comb begin
        pc_src = PC_SEQ;
        if (exc_req) begin
            pc_src = PC_EXC;
        end else if (!in_enter) begin
            // pc[31] masks the timer while the handler runs
            if (irq && !pc[31] && !stall) begin
                pc_src = PC_IRQ;
            end else if (branch_taken) begin
                pc_src = PC_BR;
            end else if (jump_taken) begin
                pc_src = PC_JMP;
            end else if (stall) begin
                pc_src = PC_HOLD;
            end
        end
    end

    always_comb begin
        pc_next = seq_pc(pc);
        case (pc_src)
            PC_EXC:  pc_next = EXC_VECTOR;
            PC_IRQ:  pc_next = IRQ_VECTOR;
            PC_BR:   pc_next = branch_target;
            PC_JMP:  pc_next = jump_target;
            PC_HOLD: pc_next = pc;
            default: pc_next = seq_pc(pc);
        endcase
    end

endmodule

// File: rtl/fetch_exception_ctrl.sv
// Fetch PC owner: next-PC selection, IF/ID flush strobes and EPC capture for $k0.
//   state    | meaning
//   ST_RUN   | normal fetch; exception, interrupt, branch, jump and stall all considered
//   ST_ENTER | one cycle after a vector load; only ExcReq can redirect, fetch advances
module fetch_exception_ctrl
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        JumpTaken,
    input  logic [31:0] JumpTarget,
    input  logic        IRQ,
    input  logic        ExcReq,
    output logic [31:0] PC,
    output logic [31:0] IdPC,
    output logic        FlushIF,
    output logic        FlushID,
    output logic [31:0] EPC,
    output logic        EPCWrite,
    output logic        InKernel,
    output logic [15:0] IrqCount
);

    fetch_state_e state, state_next;
    pc_src_e      pc_src;
    logic [31:0]  pc_next;
    logic [31:0]  idpc_next;
    logic [31:0]  epc_next;
    logic         trap;
    logic         flush_if_next;
    logic         flush_id_next;

    pc_next_mux u_pc_next_mux (
        .in_enter      (state == ST_ENTER),
        .exc_req       (ExcReq),
        .irq           (IRQ),
        .stall         (Stall),
        .branch_taken  (BranchTaken),
        .branch_target (BranchTarget),
        .jump_taken    (JumpTaken),
        .jump_target   (JumpTarget),
        .pc            (PC),
        .pc_src        (pc_src),
        .pc_next       (pc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = ST_RUN;
        if (pc_src == PC_IRQ || pc_src == PC_EXC) begin
            state_next = ST_ENTER;
        end
    end

    always_comb begin
        trap          = (pc_src == PC_IRQ) || (pc_src == PC_EXC);
        flush_if_next = trap || (pc_src == PC_BR) || (pc_src == PC_JMP);
        flush_id_next = trap;
        epc_next      = EPC;
        if (pc_src == PC_EXC) begin
            epc_next = IdPC + 32'd4;
        end else if (pc_src == PC_IRQ) begin
            // Return to whatever the redirected/flushed instruction would have been
            if (BranchTaken) begin
                epc_next = BranchTarget;
            end else if (JumpTaken) begin
                epc_next = JumpTarget;
            end else begin
                epc_next = IdPC;
            end
        end
        if (flush_if_next) begin
            idpc_next = 32'd0;
        end else if (pc_src == PC_HOLD) begin
            idpc_next = IdPC;
        end else begin
            idpc_next = PC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            PC       <= RESET_PC;
            IdPC     <= 32'd0;
            EPC      <= 32'd0;
            IrqCount <= 16'd0;
            FlushIF  <= 1'b0;
            FlushID  <= 1'b0;
            EPCWrite <= 1'b0;
        end else begin
            PC       <= pc_next;
            IdPC     <= idpc_next;
            EPC      <= epc_next;
            FlushIF  <= flush_if_next;
            FlushID  <= flush_id_next;
            EPCWrite <= trap;
            if (pc_src == PC_IRQ && IrqCount != 16'hFFFF) begin
                IrqCount <= IrqCount + 16'd1;
            end
        end
    end

    assign InKernel = PC[31];

endmodule

// File: tb/tb_fetch_exception_ctrl.sv
// Scoreboarded bench for fetch_exception_ctrl: directed trap scenarios, then random traffic
// checked against a behavioural model of the fetch rules.
module tb_fetch_exception_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = 32'd0;
    logic        JumpTaken = 1'b0;
    logic [31:0] JumpTarget = 32'd0;
    logic        IRQ = 1'b0;
    logic        ExcReq = 1'b0;
    logic [31:0] PC, IdPC, EPC;
    logic        FlushIF, FlushID, EPCWrite, InKernel;
    logic [15:0] IrqCount;

    int checks = 0;
    int errors = 0;

    fetch_exception_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .JumpTaken    (JumpTaken),
        .JumpTarget   (JumpTarget),
        .IRQ          (IRQ),
        .ExcReq       (ExcReq),
        .PC           (PC),
        .IdPC         (IdPC),
        .FlushIF      (FlushIF),
        .FlushID      (FlushID),
        .EPC          (EPC),
        .EPCWrite     (EPCWrite),
        .InKernel     (InKernel),
        .IrqCount     (IrqCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] idpc;
        logic [31:0] epc;
        logic [15:0] cnt;
        logic        fif;
        logic        fid;
        logic        ewr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] epc_q[$];

    // Reference model state: architectural view after each clock edge
    logic [31:0] m_pc = 32'h0040_0000;
    logic [31:0] m_idpc = 32'd0;
    logic [31:0] m_epc = 32'd0;
    int          m_irqs = 0;
    bit          m_just_vectored = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step();
        exp_t e;
        logic [31:0] nxt;
        bit redirect, trapped;
        redirect = 1'b0;
        trapped  = 1'b0;
        if (reset) begin
            m_pc = 32'h0040_0000;
            m_idpc = 32'd0;
            m_epc = 32'd0;
            m_irqs = 0;
            m_just_vectored = 1'b0;
        end else begin
            if (ExcReq) begin
                nxt = 32'h8040_0008;
                m_epc = m_idpc + 32'd4;
                trapped = 1'b1;
            end else if (!m_just_vectored && IRQ && m_pc < 32'h8000_0000 && !Stall) begin
                nxt = 32'h8040_0004;
                m_epc = BranchTaken ? BranchTarget : (JumpTaken ? JumpTarget : m_idpc);
                if (m_irqs < 65535) m_irqs++;
                trapped = 1'b1;
            end else if (!m_just_vectored && BranchTaken) begin
                nxt = BranchTarget;
                redirect = 1'b1;
            end else if (!m_just_vectored && JumpTaken) begin
                nxt = JumpTarget;
                redirect = 1'b1;
            end else if (!m_just_vectored && Stall) begin
                nxt = m_pc;
            end else begin
                // user space wraps within the lower 2 GiB, kernel space within the upper
                nxt = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
            end
            if (trapped || redirect) m_idpc = 32'd0;
            else if (!(Stall && !m_just_vectored)) m_idpc = m_pc;
            m_pc = nxt;
            m_just_vectored = trapped;
            if (trapped) epc_q.push_back(m_epc);
        end
        e.pc   = m_pc;
        e.idpc = m_idpc;
        e.epc  = m_epc;
        e.cnt  = 16'(m_irqs);
        e.fif  = trapped || redirect;
        e.fid  = trapped;
        e.ewr  = trapped;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit rst, input bit st, input bit br, input logic [31:0] bt,
                         input bit jp, input logic [31:0] jt, input bit irq_i, input bit exc);
        @(negedge clk);
        reset = rst;
        Stall = st;
        BranchTaken = br;
        BranchTarget = bt;
        JumpTaken = jp;
        JumpTarget = jt;
        IRQ = irq_i;
        ExcReq = exc;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit irq_i);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, irq_i, 1'b0);
    endtask

    task automatic jump(input logic [31:0] t, input bit irq_i);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, t, irq_i, 1'b0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc", PC, e.pc);
            chk("idpc", IdPC, e.idpc);
            chk("epc", EPC, e.epc);
            chk("irqcount", 32'(IrqCount), 32'(e.cnt));
            chk("flushif", 32'(FlushIF), 32'(e.fif));
            chk("flushid", 32'(FlushID), 32'(e.fid));
            chk("epcwrite", 32'(EPCWrite), 32'(e.ewr));
            chk("inkernel", 32'(InKernel), 32'(e.pc[31]));
        end
        if (EPCWrite === 1'b1) begin
            if (epc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL epc_strobe actual=unexpected_write(%h) required=no_write", EPC);
            end else begin
                chk("epc_strobe", EPC, epc_q.pop_front());
            end
        end
    end

    initial begin
        // reset for 3 cycles, then sequential fetch
        repeat (3) drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("reset_pc", PC, 32'h0040_0000);
        chk("reset_irqcount", 32'(IrqCount), 32'd0);
        idle(1'b0);
        chk("seq_pc1", PC, 32'h0040_0004);
        idle(1'b0);
        chk("seq_pc2", PC, 32'h0040_0008);

        // user-space wrap never carries into bit 31
        jump(32'h7FFF_FFFC, 1'b0);
        idle(1'b0);
        chk("wrap_pc", PC, 32'h0000_0000);

        // interrupt with no redirect saves IdPC, then jr $26 resumes
        jump(32'h0040_0120, 1'b0);
        idle(1'b0);
        chk("irq_setup_idpc", IdPC, 32'h0040_0120);
        idle(1'b1);
        chk("irq_pc", PC, 32'h8040_0004);
        chk("irq_epc", EPC, 32'h0040_0120);
        chk("irq_epcwrite", 32'(EPCWrite), 32'd1);
        chk("irq_count1", 32'(IrqCount), 32'd1);
        idle(1'b0);
        chk("irq_strobe_one_cycle", 32'(EPCWrite), 32'd0);
        jump(32'h0040_0120, 1'b0);
        chk("irq_return", PC, 32'h0040_0120);

        // interrupt coinciding with a taken branch returns to the branch target
        drive(1'b0, 1'b0, 1'b1, 32'h0040_00DC, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("irq_br_pc", PC, 32'h8040_0004);
        chk("irq_br_epc", EPC, 32'h0040_00DC);

        // held IRQ is masked in kernel, re-enters right after return to user
        idle(1'b1);
        jump(32'h8040_0158, 1'b1);
        chk("kernel_pc", PC, 32'h8040_0158);
        idle(1'b1);
        chk("kernel_masked", PC, 32'h8040_015C);
        jump(32'h0040_0200, 1'b1);
        chk("user_return", PC, 32'h0040_0200);
        idle(1'b1);
        chk("reentry_pc", PC, 32'h8040_0004);
        chk("reentry_count", 32'(IrqCount), 32'd3);

        // stall defers a pending interrupt
        idle(1'b0);
        jump(32'h0040_003C, 1'b0);
        repeat (2) drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("stall_hold", PC, 32'h0040_003C);
        idle(1'b1);
        chk("stall_release_irq", PC, 32'h8040_0004);

        // exception under stall, then reset inside the entry window
        idle(1'b0);
        jump(32'h0040_0050, 1'b0);
        idle(1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("exc_pc", PC, 32'h8040_0008);
        chk("exc_epc", EPC, 32'h0040_0054);
        chk("exc_flushif", 32'(FlushIF), 32'd1);
        chk("exc_flushid", 32'(FlushID), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("reset_in_enter_pc", PC, 32'h0040_0000);
        chk("reset_in_enter_ewr", 32'(EPCWrite), 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] bt, jt;
            bt = {$urandom_range(1), 31'($urandom) & 31'h7FFF_FFFC};
            jt = {($urandom_range(99) < 30) ? 1'b1 : 1'b0, 31'($urandom) & 31'h7FFF_FFFC};
            drive($urandom_range(99) < 2, $urandom_range(99) < 25, $urandom_range(99) < 15, bt,
                  $urandom_range(99) < 15, jt, $urandom_range(99) < 30, $urandom_range(99) < 4);
        end
        idle(1'b0);
        idle(1'b0);
        @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("epc_q_drained", 32'(epc_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
